ctrl_bus_arbiter: RTL and testbench



---
 rtl/ctrl_bus_arbiter_pkg.sv | 25 ++
 rtl/ctrl_bus_arbiter_rr_pick2.sv | 22 ++
 rtl/ctrl_bus_arbiter.sv | 155 +++++++++++++++
 tb/tb_ctrl_bus_arbiter.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_bus_arbiter_pkg.sv
// Shared types and defaults for the two-master control bus arbiter.
// Holds the state encoding, the owner encoding and the hold-counter width helper.
package ctrl_bus_arbiter_pkg;

  localparam int DEF_ADDR_W   = 8;
  localparam int DEF_DATA_W   = 8;
  localparam int DEF_MAX_HOLD = 64;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_GRANT = 2'd1,
    ARB_TURN  = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWNER_M0 = 1'b0,
    OWNER_M1 = 1'b1
  } owner_t;

  // A zero limit still needs a one-bit counter.
  function automatic int hold_width(input int max_hold);
    return (max_hold > 0) ? $clog2(max_hold + 1) : 1;
  endfunction

endpackage

// File: rtl/ctrl_bus_arbiter_rr_pick2.sv
// Combinational two-way round-robin pick: a lone requester wins,
// on a tie the master that did not own the bus last wins.
module rr_pick2
  import ctrl_bus_arbiter_pkg::*;
(
  input  logic   req0,
  input  logic   req1,
  input  owner_t last_owner,
  output logic   valid,
  output owner_t pick
);

  always_comb begin
    valid = req0 | req1;
    if (req0 && req1) begin
      pick = (last_owner == OWNER_M0) ? OWNER_M1 : OWNER_M0;
    end else begin
      pick = req1 ? OWNER_M1 : OWNER_M0;
    end
  end

endmodule

// File: rtl/ctrl_bus_arbiter.sv
// Two-master round-robin arbiter for the 8-bit control bus with a one-cycle
// turnaround between owners and a bounded hold time under contention.
module ctrl_bus_arbiter
  import ctrl_bus_arbiter_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int MAX_HOLD = DEF_MAX_HOLD
) (
  input  logic              mclk,
  input  logic              reset,
  input  logic              m0_req,
  output logic              m0_gnt,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_rvalid,
  input  logic              m1_req,
  output logic              m1_gnt,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m_rdata,
  output logic [ADDR_W-1:0] bus_addr,
  output logic              bus_read,
  output logic              bus_write,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic [DATA_W-1:0] bus_rdata,
  output logic              protocol_err
);

  localparam int              HOLD_W   = hold_width(MAX_HOLD);
  localparam logic [HOLD_W-1:0] HOLD_LIM = HOLD_W'(MAX_HOLD);

  arb_state_t        state_q, state_d;
  owner_t            last_owner_q, last_owner_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              err_q, err_d;
  logic              gnt0_d, gnt1_d;

  logic              own_req, oth_req, own_read, own_write;
  logic [ADDR_W-1:0] own_addr;
  logic [DATA_W-1:0] own_wdata;
  logic              conflict, preempt;
  logic              pick_valid;
  owner_t            pick;

  rr_pick2 u_pick (
    .req0       (m0_req),
    .req1       (m1_req),
    .last_owner (last_owner_q),
    .valid      (pick_valid),
    .pick       (pick)
  );

  // Owner mux: only the registered grant lets a master's strobes through.
  always_comb begin
    own_req   = 1'b0;
    oth_req   = 1'b0;
    own_read  = 1'b0;
    own_write = 1'b0;
    own_addr  = '0;
    own_wdata = '0;
    if (m0_gnt) begin
      own_req   = m0_req;
      oth_req   = m1_req;
      own_read  = m0_read;
      own_write = m0_write;
      own_addr  = m0_addr;
      own_wdata = m0_wdata;
    end else if (m1_gnt) begin
      own_req   = m1_req;
      oth_req   = m0_req;
      own_read  = m1_read;
      own_write = m1_write;
      own_addr  = m1_addr;
      own_wdata = m1_wdata;
    end
  end

  assign conflict     = own_read & own_write;
  assign bus_addr     = own_addr;
  assign bus_wdata    = own_wdata;
  assign bus_read     = own_read & ~conflict;
  assign bus_write    = own_write & ~conflict;
  assign m_rdata      = bus_rdata;
  assign m0_rvalid    = m0_gnt & m0_read & ~m0_write;
  assign m1_rvalid    = m1_gnt & m1_read & ~m1_write;
  assign protocol_err = err_q | conflict;

  // Timeout only fires between strobes so an access in flight is never cut.
  assign preempt = (MAX_HOLD != 0) && (hold_q == HOLD_LIM) && oth_req
                   && !own_read && !own_write;

  always_comb begin
    state_d      = state_q;
    gnt0_d       = m0_gnt;
    gnt1_d       = m1_gnt;
    last_owner_d = last_owner_q;
    hold_d       = hold_q;
    err_d        = err_q | conflict;
    case (state_q)
      ARB_IDLE, ARB_TURN: begin
        gnt0_d = 1'b0;
        gnt1_d = 1'b0;
        hold_d = '0;
        if (pick_valid) begin
          state_d = ARB_GRANT;
          gnt0_d  = (pick == OWNER_M0);
          gnt1_d  = (pick == OWNER_M1);
        end else begin
          state_d = ARB_IDLE;
        end
      end
      ARB_GRANT: begin
        if (hold_q != HOLD_LIM) hold_d = hold_q + 1'b1;
        if (!own_req || preempt) begin
          state_d      = ARB_TURN;
          gnt0_d       = 1'b0;
          gnt1_d       = 1'b0;
          last_owner_d = m1_gnt ? OWNER_M1 : OWNER_M0;
          hold_d       = '0;
        end
      end
      default: begin
        state_d = ARB_IDLE;
        gnt0_d  = 1'b0;
        gnt1_d  = 1'b0;
        hold_d  = '0;
      end
    endcase
  end

  always_ff @(posedge mclk) begin
    if (reset) begin
      state_q      <= ARB_IDLE;
      m0_gnt       <= 1'b0;
      m1_gnt       <= 1'b0;
      last_owner_q <= OWNER_M1;
      hold_q       <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      m0_gnt       <= gnt0_d;
      m1_gnt       <= gnt1_d;
      last_owner_q <= last_owner_d;
      hold_q       <= hold_d;
      err_q        <= err_d;
    end
  end

endmodule

// File: tb/tb_ctrl_bus_arbiter.sv
// Scoreboard bench for ctrl_bus_arbiter: directed stimulus queues per-cycle
// expectations, a negedge monitor pops and compares them against the outputs.
module tb_ctrl_bus_arbiter;

  typedef struct packed {
    logic [1:0] gnt;
    logic       rd;
    logic       wr;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata;
    logic [1:0] rv;
    logic       err;
  } obs_t;

  logic       mclk, reset;
  logic       m0_req, m0_gnt, m0_read, m0_write, m0_rvalid;
  logic [7:0] m0_addr, m0_wdata;
  logic       m1_req, m1_gnt, m1_read, m1_write, m1_rvalid;
  logic [7:0] m1_addr, m1_wdata;
  logic [7:0] m_rdata, bus_addr, bus_wdata, bus_rdata;
  logic       bus_read, bus_write, protocol_err;

  int    cyc;
  int    tests;
  int    fails;
  logic  done;
  int    cq[$];
  string nq[$];
  obs_t  eq[$];
  obs_t  act, expv;
  int    ecyc;
  string ename;

  ctrl_bus_arbiter #(.ADDR_W(8), .DATA_W(8), .MAX_HOLD(4)) dut (
    .mclk(mclk), .reset(reset),
    .m0_req(m0_req), .m0_gnt(m0_gnt), .m0_addr(m0_addr), .m0_read(m0_read),
    .m0_write(m0_write), .m0_wdata(m0_wdata), .m0_rvalid(m0_rvalid),
    .m1_req(m1_req), .m1_gnt(m1_gnt), .m1_addr(m1_addr), .m1_read(m1_read),
    .m1_write(m1_write), .m1_wdata(m1_wdata), .m1_rvalid(m1_rvalid),
    .m_rdata(m_rdata), .bus_addr(bus_addr), .bus_read(bus_read),
    .bus_write(bus_write), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
    .protocol_err(protocol_err)
  );

  initial mclk = 1'b0;
  always #5 mclk = ~mclk;

  task automatic step();
    @(posedge mclk);
    #1;
    cyc = cyc + 1;
  endtask

  task automatic expect_now(input string name, input logic [1:0] g, input logic rd,
                            input logic wr, input logic [7:0] a, input logic [7:0] wd,
                            input logic [7:0] rdat, input logic [1:0] rv, input logic e);
    cq.push_back(cyc);
    nq.push_back(name);
    eq.push_back({g, rd, wr, a, wd, rdat, rv, e});
  endtask

  task automatic idle_inputs();
    m0_req = 0; m0_read = 0; m0_write = 0; m0_addr = 8'h00; m0_wdata = 8'h00;
    m1_req = 0; m1_read = 0; m1_write = 0; m1_addr = 8'h00; m1_wdata = 8'h00;
  endtask

  // Monitor: compare whatever expectation is due this cycle.
  always @(negedge mclk) begin
    act = {m1_gnt, m0_gnt, bus_read, bus_write, bus_addr, bus_wdata, m_rdata,
           m1_rvalid, m0_rvalid, protocol_err};
    if (cq.size() != 0 && cq[0] <= cyc) begin
      ecyc  = cq.pop_front();
      ename = nq.pop_front();
      expv  = eq.pop_front();
      tests = tests + 1;
      if (ecyc != cyc) begin
        fails = fails + 1;
        $display("FAIL %s expectation for cycle %0d not checked until cycle %0d", ename, ecyc, cyc);
      end else if (act !== expv) begin
        fails = fails + 1;
        $display("FAIL %s cyc=%0d got gnt=%b rd=%b wr=%b addr=%h wd=%h rdata=%h rv=%b err=%b expected gnt=%b rd=%b wr=%b addr=%h wd=%h rdata=%h rv=%b err=%b",
                 ename, cyc, act.gnt, act.rd, act.wr, act.addr, act.wdata, act.rdata, act.rv, act.err,
                 expv.gnt, expv.rd, expv.wr, expv.addr, expv.wdata, expv.rdata, expv.rv, expv.err);
      end
    end
    if (done) begin
      if (cq.size() != 0) begin
        tests = tests + 1;
        fails = fails + 1;
        $display("FAIL drain %0d expectations never checked, expected 0", cq.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    cyc = 0; tests = 0; fails = 0; done = 1'b0;
    reset = 1'b1; bus_rdata = 8'h5A;
    idle_inputs();
    step(); step();
    expect_now("reset", 2'b00, 0, 0, 8'h00, 8'h00, 8'h5A, 2'b00, 0);
    step();

    // Single requester write; m1 strobes (even a read+write clash) are ignored.
    reset = 1'b0; m0_req = 1;
    expect_now("t1_idle", 2'b00, 0, 0, 8'h00, 8'h00, 8'h5A, 2'b00, 0);
    step();
    m0_write = 1; m0_addr = 8'h12; m0_wdata = 8'hA5;
    m1_read = 1; m1_write = 1; m1_addr = 8'h77; m1_wdata = 8'hEE;
    expect_now("t1_wr", 2'b01, 0, 1, 8'h12, 8'hA5, 8'h5A, 2'b00, 0);
    step();
    idle_inputs();
    expect_now("t1_rel", 2'b01, 0, 0, 8'h00, 8'h00, 8'h5A, 2'b00, 0);
    step();
    expect_now("t1_turn", 2'b00, 0, 0, 8'h00, 8'h00, 8'h5A, 2'b00, 0);
    step();
    expect_now("t1_idle2", 2'b00, 0, 0, 8'h00, 8'h00, 8'h5A, 2'b00, 0);
    step();

    // Tie from reset: m0 first, release at cycle 5, m1 at cycle 7.
    reset = 1'b1; step(); step();
    reset = 1'b0; m0_req = 1; m1_req = 1;
    expect_now("t2_c0", 2'b00, 0, 0, 8'h00, 8'h00, 8'h5A, 2'b00, 0);
    step();
    for (int i = 1; i <= 4; i++) begin
      expect_now("t2_m0", 2'b01, 0, 0, 8'h00, 8'h00, 8'h5A, 2'b00, 0);
      step();
    end
    m0_req = 0;
    expect_now("t2_rel", 2'b01, 0, 0, 8'h00, 8'h00, 8'h5A, 2'b00, 0);
    step();
    expect_now("t2_turn", 2'b00, 0, 0, 8'h00, 8'h00, 8'h5A, 2'b00, 0);
    step();

    // m1 holds with strobes low while m0 waits: preempted after 5 grant cycles.
    m0_req = 1;
    expect_now("t2_m1", 2'b10, 0, 0, 8'h00, 8'h00, 8'h5A, 2'b00, 0);
    step();
    for (int i = 0; i < 4; i++) begin
      expect_now("t3_hold", 2'b10, 0, 0, 8'h00, 8'h00, 8'h5A, 2'b00, 0);
      step();
    end
    expect_now("t3_turn", 2'b00, 0, 0, 8'h00, 8'h00, 8'h5A, 2'b00, 0);
    step();
    m0_req = 0;
    expect_now("t3_m0", 2'b01, 0, 0, 8'h00, 8'h00, 8'h5A, 2'b00, 0);
    step();
    m0_req = 1;
    expect_now("t3b_turn", 2'b00, 0, 0, 8'h00, 8'h00, 8'h5A, 2'b00, 0);
    step();

    // m1 keeps a read strobe up past the hold limit: preemption waits.
    m1_read = 1; m1_addr = 8'h33;
    expect_now("t3b_rd", 2'b10, 1, 0, 8'h33, 8'h00, 8'h5A, 2'b10, 0);
    step();
    for (int i = 0; i < 5; i++) begin
      expect_now("t3b_defer", 2'b10, 1, 0, 8'h33, 8'h00, 8'h5A, 2'b10, 0);
      step();
    end
    m1_read = 0; m1_addr = 8'h00;
    expect_now("t3b_drop", 2'b10, 0, 0, 8'h00, 8'h00, 8'h5A, 2'b00, 0);
    step();
    expect_now("t3b_turn2", 2'b00, 0, 0, 8'h00, 8'h00, 8'h5A, 2'b00, 0);
    step();

    // m0 read with slave data returned in the same cycle.
    m0_read = 1; m0_addr = 8'h40; bus_rdata = 8'h3C; m1_read = 1;
    expect_now("t4_rd", 2'b01, 1, 0, 8'h40, 8'h00, 8'h3C, 2'b01, 0);
    step();

    // Read and write together: strobes blocked, error sticky.
    m0_write = 1; m0_addr = 8'h41; m0_wdata = 8'h99; m1_read = 0;
    expect_now("t5_conf", 2'b01, 0, 0, 8'h41, 8'h99, 8'h3C, 2'b00, 1);
    step();
    m0_read = 0; m0_write = 0; m0_addr = 8'h00; m0_wdata = 8'h00; m0_req = 0;
    expect_now("t5_sticky", 2'b01, 0, 0, 8'h00, 8'h00, 8'h3C, 2'b00, 1);
    step();
    expect_now("t5_turn", 2'b00, 0, 0, 8'h00, 8'h00, 8'h3C, 2'b00, 1);
    step();

    // Reset while m1 writes: grant and error clear at the edge, m0 wins after.
    m1_write = 1; m1_addr = 8'h55; m1_wdata = 8'h66;
    expect_now("t6_wr", 2'b10, 0, 1, 8'h55, 8'h66, 8'h3C, 2'b00, 1);
    step();
    reset = 1'b1; m0_req = 1;
    expect_now("t6_rst_cyc", 2'b10, 0, 1, 8'h55, 8'h66, 8'h3C, 2'b00, 1);
    step();
    reset = 1'b0;
    expect_now("t6_post", 2'b00, 0, 0, 8'h00, 8'h00, 8'h3C, 2'b00, 0);
    step();
    expect_now("t6_m0wins", 2'b01, 0, 0, 8'h00, 8'h00, 8'h3C, 2'b00, 0);
    step();

    done = 1'b1;
  end

endmodule
